// File: rtl/vpu_pkg.sv
// Shared vector-unit constants: default widths and the store-streamer FSM encoding.
package vpu_pkg;

    localparam int unsigned DATA_WIDTH    = 128;
    localparam int unsigned ADDR_WIDTH    = 4;
    localparam int unsigned BEAT_WIDTH    = 32;
    localparam int unsigned BEATS_PER_REG = DATA_WIDTH / BEAT_WIDTH;

    localparam int unsigned STATE_WIDTH = 2;
    localparam logic [STATE_WIDTH-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_WIDTH-1:0] ST_FETCH = 2'd1;
    localparam logic [STATE_WIDTH-1:0] ST_SEND  = 2'd2;

endpackage

// File: rtl/beat_serializer.sv
// Holds one vector register and emits it as least-significant-first beats
// over a valid/ready port; flags the last beat of the final register.
module beat_serializer #(
    parameter int unsigned DATA_WIDTH = vpu_pkg::DATA_WIDTH,
    parameter int unsigned BEAT_WIDTH = vpu_pkg::BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [BEAT_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  reg_done_c
);

    localparam int unsigned BEATS = DATA_WIDTH / BEAT_WIDTH;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [DATA_WIDTH-1:0] buf_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  final_reg_q;
    logic                  xfer_c;
    logic [IDX_W-1:0]      idx_inc_c;

    assign xfer_c     = out_valid && out_ready;
    assign reg_done_c = xfer_c && (idx_q == LAST_IDX);
    assign idx_inc_c  = idx_q + IDX_W'(1);
    assign out_data   = buf_q[BEAT_WIDTH-1:0];

    // out_last is computed one beat ahead so it comes straight from a flop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q       <= '0;
            idx_q       <= '0;
            final_reg_q <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
        end else if (load) begin
            buf_q       <= load_data;
            idx_q       <= '0;
            final_reg_q <= load_last;
            out_valid   <= 1'b1;
            out_last    <= load_last && (BEATS == 1);
        end else if (reg_done_c) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
        end else if (xfer_c) begin
            buf_q       <= buf_q >> BEAT_WIDTH;
            idx_q       <= idx_inc_c;
            out_last    <= final_reg_q && (idx_inc_c == LAST_IDX);
        end
    end

endmodule

// File: rtl/vreg_store_streamer.sv
// Streams a contiguous run of vector registers out of the register file as
// narrow beats; one FETCH bubble per register, address wraps modulo 2**ADDR_WIDTH.
module vreg_store_streamer #(
    parameter int unsigned DATA_WIDTH = vpu_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = vpu_pkg::ADDR_WIDTH,
    parameter int unsigned BEAT_WIDTH = vpu_pkg::BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_count,
    output logic [ADDR_WIDTH-1:0] rf_r_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BEAT_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    import vpu_pkg::STATE_WIDTH;
    import vpu_pkg::ST_IDLE;
    import vpu_pkg::ST_FETCH;
    import vpu_pkg::ST_SEND;

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cur_q, cur_d;
    logic [ADDR_WIDTH:0]    rem_q, rem_d;
    logic                   done_d;
    logic                   load_c;
    logic                   load_last_c;
    logic                   reg_done_c;
    logic                   accept_c;
    logic [ADDR_WIDTH:0]    count_clamped_c;

    assign accept_c        = cmd_valid && cmd_ready;
    assign count_clamped_c = (cmd_count > MAX_COUNT) ? MAX_COUNT : cmd_count;
    assign rf_r_addr       = cur_q;

    // State and status registers; cmd_ready/busy follow the next state so they are flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            rem_q     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            rem_q     <= rem_d;
            done      <= done_d;
            busy      <= (state_d != ST_IDLE);
            cmd_ready <= (state_d == ST_IDLE);
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        load_c      = 1'b0;
        load_last_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    cur_d = cmd_base;
                    rem_d = count_clamped_c;
                    if (count_clamped_c == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                load_c      = 1'b1;
                load_last_c = (rem_q == (ADDR_WIDTH+1)'(1));
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (reg_done_c) begin
                    rem_d = rem_q - (ADDR_WIDTH+1)'(1);
                    cur_d = cur_q + ADDR_WIDTH'(1);
                    if (rem_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    beat_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_c),
        .load_data  (rf_data),
        .load_last  (load_last_c),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .reg_done_c (reg_done_c)
    );

endmodule

// File: tb/tb_vreg_store_streamer.sv
// Self-checking bench for vreg_store_streamer: a table of commands plus
// hand-written sequences for exact latency, reset abort and snapshot hazard.
module tb_vreg_store_streamer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_base;
    logic [4:0]   cmd_count;
    logic [3:0]   rf_r_addr;
    logic [127:0] rf_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         busy;
    logic         done;

    logic [127:0] rf [16];
    assign rf_data = rf[rf_r_addr];

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] base;
        logic [4:0] count;
        int         mode;
        int         exp_beats;
        int         exp_regs;
        int         exp_done_cyc;
    } vec_t;

    vec_t vecs [6];

    vreg_store_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_count (cmd_count),
        .rf_r_addr (rf_r_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [31:0] word_of(input int r, input int j);
        if (r == 3) return 32'h1111_1111 * 32'(j);
        return {8'hA5, 8'(r), 8'h00, 8'(j)};
    endfunction

    function automatic logic [127:0] reg_of(input int r);
        logic [127:0] v;
        for (int j = 0; j < 4; j++) v[j*32 +: 32] = word_of(r, j);
        return v;
    endfunction

    function automatic logic ready_pat(input int mode, input int n);
        if (mode == 0) return 1'b1;
        return ((n % 4) == 0) || ((n % 4) == 3);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] beats [$];
        int          last_pos [$];
        logic [3:0]  addrs [$];
        int          done_cyc;
        int          fetches;
        int          overlap;
        int          n;
        logic        stall_pend;
        logic [31:0] stall_data;
        logic        stall_last;
        int          nb;

        n = 0;
        while (!cmd_ready && n < 50) begin
            tick;
            n++;
        end
        chk($sformatf("v%0d idle", idx), 128'(cmd_ready), 128'(1));

        cmd_valid = 1'b1;
        cmd_base  = v.base;
        cmd_count = v.count;
        out_ready = ready_pat(v.mode, 0);
        tick;
        cmd_valid  = 1'b0;
        done_cyc   = -1;
        fetches    = 0;
        overlap    = 0;
        stall_pend = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;

        for (int c = 1; c < 300; c++) begin
            out_ready = ready_pat(v.mode, c);
            if (stall_pend) begin
                chk($sformatf("v%0d stall valid", idx), 128'(out_valid), 128'(1));
                chk($sformatf("v%0d stall data", idx), 128'(out_data), 128'(stall_data));
                chk($sformatf("v%0d stall last", idx), 128'(out_last), 128'(stall_last));
                stall_pend = 1'b0;
            end
            if (done && out_valid) overlap++;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (busy && !out_valid) begin
                fetches++;
                addrs.push_back(rf_r_addr);
            end
            if (out_valid && out_ready) begin
                beats.push_back(out_data);
                if (out_last) last_pos.push_back(beats.size() - 1);
            end else if (out_valid) begin
                stall_pend = 1'b1;
                stall_data = out_data;
                stall_last = out_last;
            end
            tick;
        end

        chk($sformatf("v%0d done cycle", idx), 128'(done_cyc), 128'(v.exp_done_cyc));
        chk($sformatf("v%0d beat count", idx), 128'(beats.size()), 128'(v.exp_beats));
        chk($sformatf("v%0d fetch cycles", idx), 128'(fetches), 128'(v.exp_regs));
        chk($sformatf("v%0d done with valid", idx), 128'(overlap), 128'(0));
        nb = (beats.size() < v.exp_beats) ? beats.size() : v.exp_beats;
        for (int k = 0; k < nb; k++)
            chk($sformatf("v%0d beat %0d", idx, k), 128'(beats[k]),
                128'(word_of((int'(v.base) + k / 4) % 16, k % 4)));
        for (int i = 0; i < addrs.size() && i < v.exp_regs; i++)
            chk($sformatf("v%0d addr %0d", idx, i), 128'(addrs[i]),
                128'((int'(v.base) + i) % 16));
        chk($sformatf("v%0d last count", idx), 128'(last_pos.size()),
            128'((v.exp_beats > 0) ? 1 : 0));
        if (last_pos.size() == 1)
            chk($sformatf("v%0d last position", idx), 128'(last_pos[0]), 128'(v.exp_beats - 1));
    endtask

    initial begin
        vec_t tmp;

        for (int r = 0; r < 16; r++) rf[r] = reg_of(r);

        //          base   count  mode beats regs done
        vecs[0] = '{4'd3,  5'd1,  0,   4,    1,   6};
        vecs[1] = '{4'd14, 5'd3,  0,   12,   3,   16};
        vecs[2] = '{4'd7,  5'd2,  1,   8,    2,   17};
        vecs[3] = '{4'd9,  5'd0,  0,   0,    0,   1};
        vecs[4] = '{4'd0,  5'd20, 0,   64,   16,  81};
        vecs[5] = '{4'd5,  5'd16, 0,   64,   16,  81};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_count = '0;
        out_ready = 1'b0;
        tick;
        tick;
        chk("rst cmd_ready", 128'(cmd_ready), 128'(1));
        chk("rst out_valid", 128'(out_valid), 128'(0));
        chk("rst out_last", 128'(out_last), 128'(0));
        chk("rst done", 128'(done), 128'(0));
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst rf_r_addr", 128'(rf_r_addr), 128'(0));
        chk("rst out_data", 128'(out_data), 128'(0));
        rst_n = 1'b1;
        tick;

        // Exact cycle timing of a single register
        out_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_base  = 4'd3;
        cmd_count = 5'd1;
        tick;
        cmd_valid = 1'b0;
        chk("single c1 out_valid", 128'(out_valid), 128'(0));
        chk("single c1 busy", 128'(busy), 128'(1));
        chk("single c1 rf_r_addr", 128'(rf_r_addr), 128'(3));
        chk("single c1 cmd_ready", 128'(cmd_ready), 128'(0));
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("single beat%0d valid", k), 128'(out_valid), 128'(1));
            chk($sformatf("single beat%0d data", k), 128'(out_data), 128'(32'h1111_1111 * 32'(k)));
            chk($sformatf("single beat%0d last", k), 128'(out_last), 128'((k == 3) ? 1 : 0));
        end
        tick;
        chk("single done", 128'(done), 128'(1));
        chk("single done valid", 128'(out_valid), 128'(0));
        chk("single done busy", 128'(busy), 128'(0));
        chk("single done cmd_ready", 128'(cmd_ready), 128'(1));
        tick;
        chk("single done pulse width", 128'(done), 128'(0));

        for (int i = 0; i < 6; i++) begin
            tmp = vecs[i];
            run_vec(tmp, i);
        end

        // Reset while the second of four beats is on the bus
        out_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_base  = 4'd2;
        cmd_count = 5'd1;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        chk("abort beat1 data", 128'(out_data), 128'(word_of(2, 1)));
        rst_n = 1'b0;
        tick;
        chk("abort out_valid", 128'(out_valid), 128'(0));
        chk("abort busy", 128'(busy), 128'(0));
        chk("abort cmd_ready", 128'(cmd_ready), 128'(1));
        chk("abort done", 128'(done), 128'(0));
        chk("abort out_last", 128'(out_last), 128'(0));
        chk("abort rf_r_addr", 128'(rf_r_addr), 128'(0));
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("abort quiet%0d done", k), 128'(done), 128'(0));
            chk($sformatf("abort quiet%0d valid", k), 128'(out_valid), 128'(0));
        end
        tmp = '{4'd0, 5'd1, 0, 4, 1, 6};
        run_vec(tmp, 6);

        // Register-file write after the snapshot must not reach the stream
        out_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_base  = 4'd5;
        cmd_count = 5'd1;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        rf[5]     = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_FEED_FACE;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("snap beat%0d valid", k), 128'(out_valid), 128'(1));
            chk($sformatf("snap beat%0d data", k), 128'(out_data), 128'(word_of(5, k)));
            tick;
        end
        chk("snap done", 128'(done), 128'(1));
        rf[5] = reg_of(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
